// File: rtl/mux8_sched_pkg.sv
// Shared definitions for the 8:1 mux round-robin scheduler.
// Holds the requester/select sizes, the FSM state type and the one-hot decode helper.
package mux8_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The OR-accumulate is exact only for one-hot or all-zero inputs.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] onehot);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo 8.
// One index can be excluded, except when it is the only request.
module rr_pick8
  import mux8_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] excl_mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] eligible;
  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    excl_mask = excl_en ? (N_REQ'(1) << excl_idx) : '0;
    masked    = req & ~excl_mask;
    eligible  = (|masked) ? masked : req;
    any       = |eligible;
    idx       = '0;
    found     = 1'b0;
    cand      = '0;
    // k == N_REQ wraps back onto ptr itself, so it is searched last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && eligible[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of the shared 8:1 mux select: grants one requester for a burst of
// up to BURST_LEN accepted beats, with a valid/ready handshake to the consumer.
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy
);

  state_t             state, state_n;
  logic [N_REQ-1:0]   gnt_n;
  logic [SEL_W-1:0]   sel_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [BEAT_W-1:0]  beat_cnt, beat_cnt_n;
  logic               transfer;
  logic               last_beat;
  logic               withdraw;
  logic               rel;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_vec;
  logic               do_grant;

  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign transfer  = out_valid & out_ready;
  assign last_beat = transfer && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign withdraw  = busy && !req[sel];
  assign rel       = last_beat || withdraw;
  assign pick_vec  = N_REQ'(1) << pick_idx;
  assign do_grant  = en && pick_any;

  // A burst that ran to length hands priority away; a withdrawn requester has no request to exclude.
  rr_pick8 u_pick (
    .req      (req),
    .ptr      (ptr),
    .excl_en  (last_beat),
    .excl_idx (sel),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    sel_n      = sel;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (do_grant) begin
          state_n    = GRANT;
          gnt_n      = pick_vec;
          sel_n      = onehot_to_idx(pick_vec);
          ptr_n      = pick_idx;
          beat_cnt_n = '0;
        end
      end
      GRANT: begin
        if (rel && do_grant) begin
          gnt_n      = pick_vec;
          sel_n      = onehot_to_idx(pick_vec);
          ptr_n      = pick_idx;
          beat_cnt_n = '0;
        end else if (rel) begin
          // sel keeps its last value so the mux select never moves while idle.
          state_n    = IDLE;
          gnt_n      = '0;
          beat_cnt_n = '0;
        end else if (transfer) begin
          beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= SEL_W'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler with BURST_LEN=4: reset, rotation, withdraw,
// stall, en gating, sole requester and asynchronous reset mid-burst.
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       out_ready;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.BURST_LEN(4), .BEAT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_sel,
                              input logic e_busy, input logic e_valid);
    check_val({tag, ".gnt"}, gnt, e_gnt);
    check_val({tag, ".sel"}, {5'b0, sel}, {5'b0, e_sel});
    check_val({tag, ".busy"}, {7'b0, busy}, {7'b0, e_busy});
    check_val({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, e_valid});
  endtask

  task automatic apply_stimulus(input logic e, input logic [7:0] r, input logic rdy);
    @(negedge clk);
    en        = e;
    req       = r;
    out_ready = rdy;
  endtask

  task automatic add_vec(input logic e, input logic [7:0] r, input logic rdy, input logic [7:0] g,
                         input logic [2:0] s, input logic b, input logic v);
    vec_t t;
    t.en = e; t.req = r; t.rdy = rdy; t.gnt = g; t.sel = s; t.busy = b; t.valid = v;
    vecs.push_back(t);
  endtask

  task automatic hold_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; req = r; out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; out_ready = 1'b1;

    // Reset with every requester active, then full rotation 0..7,0 at four beats each.
    repeat (2) @(negedge clk);
    check_output("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 36; k++) begin
      logic [2:0] s;
      @(posedge clk); #1;
      s = 3'((k / 4) % 8);
      check_output($sformatf("rot%0d", k), 8'h01 << s, s, 1'b1, 1'b1);
    end

    // Withdraw, stall, en gating, sole-to-idle and same-cycle request vectors.
    add_vec(1, 8'h28, 1, 8'h08, 3, 1, 1);
    add_vec(1, 8'h28, 1, 8'h08, 3, 1, 1);
    add_vec(1, 8'h28, 1, 8'h08, 3, 1, 1);
    add_vec(1, 8'h21, 1, 8'h20, 5, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(1, 8'h21, 1, 8'h20, 5, 1, 1);
    add_vec(1, 8'h21, 1, 8'h01, 0, 1, 1);
    add_vec(1, 8'h04, 0, 8'h04, 2, 1, 1);
    for (int i = 0; i < 10; i++) add_vec(1, (i % 2) ? 8'h8D : 8'h04, 0, 8'h04, 2, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(1, 8'h05, 1, 8'h04, 2, 1, 1);
    add_vec(1, 8'h05, 1, 8'h01, 0, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(0, 8'h05, 1, 8'h01, 0, 1, 1);
    add_vec(0, 8'h05, 1, 8'h00, 0, 0, 0);
    add_vec(0, 8'h05, 1, 8'h00, 0, 0, 0);
    add_vec(1, 8'h05, 1, 8'h04, 2, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(0, 8'h05, 1, 8'h04, 2, 1, 1);
    add_vec(0, 8'h05, 1, 8'h00, 2, 0, 0);
    add_vec(0, 8'h05, 1, 8'h00, 2, 0, 0);
    add_vec(1, 8'h00, 1, 8'h00, 2, 0, 0);
    add_vec(1, 8'h80, 1, 8'h80, 7, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(1, 8'h80, 1, 8'h80, 7, 1, 1);
    add_vec(1, 8'h81, 1, 8'h01, 0, 1, 1);

    hold_reset(8'h00);
    en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].en, vecs[i].req, vecs[i].rdy);
      @(posedge clk); #1;
      check_output($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].valid);
    end

    // Sole requester is re-granted back-to-back with out_valid never dropping.
    hold_reset(8'h40);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      check_output($sformatf("sole%0d", k), 8'h40, 3'd6, 1'b1, 1'b1);
    end

    // Asynchronous reset in the middle of that burst clears outputs before the next edge.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    req = 8'h42;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst", 8'h02, 3'd1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
